// File: rtl/uart_bus_pkg.sv
// Shared constants and state types for the UART-driven bus initiator and its byte PHY.
package uart_bus_pkg;

   localparam int CLK_DIV_DEFAULT = 868;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h45;
   localparam logic [7:0] RSP_UNK   = 8'h3F;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, WAIT, RESP} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

   typedef struct packed {
      state_t    cmd;
      rx_state_t rx;
      tx_state_t tx;
   } dbg_t;

endpackage

// File: rtl/uart_bus_master_phy.sv
// 8N1 byte receiver and transmitter; one rx_valid pulse per good byte, rx_frame_err pulse on a bad stop bit.
module uart_phy
   import uart_bus_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic       txd,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_frame_err,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output rx_state_t  rx_state,
   output tx_state_t  tx_state
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

   logic [1:0]    rx_sync;
   logic          rx_prev;
   logic          rx_in;
   rx_state_t     rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_shift, rx_shift_n;
   logic          rx_valid_n, rx_err_n;

   tx_state_t     tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [3:0]    tx_bit, tx_bit_n;
   logic [9:0]    tx_shift, tx_shift_n;

   assign rx_in   = rx_sync[1];
   assign rx_data = rx_shift;
   assign tx_busy = (tx_state == TX_SEND);
   assign txd     = (tx_state == TX_SEND) ? tx_shift[0] : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync      <= 2'b11;
         rx_prev      <= 1'b1;
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         tx_state     <= TX_IDLE;
         tx_cnt       <= '0;
         tx_bit       <= '0;
         tx_shift     <= '1;
      end else begin
         rx_sync      <= {rx_sync[0], rxd};
         rx_prev      <= rx_in;
         rx_state     <= rx_state_n;
         rx_cnt       <= rx_cnt_n;
         rx_bit       <= rx_bit_n;
         rx_shift     <= rx_shift_n;
         rx_valid     <= rx_valid_n;
         rx_frame_err <= rx_err_n;
         tx_state     <= tx_state_n;
         tx_cnt       <= tx_cnt_n;
         tx_bit       <= tx_bit_n;
         tx_shift     <= tx_shift_n;
      end
   end

   // Start bit is re-checked at mid-bit so a glitch on RXD does not open a frame.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + 1'b1;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_valid_n = 1'b0;
      rx_err_n   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (rx_prev && !rx_in) rx_state_n = RX_START;
         end
         RX_START: begin
            if (rx_cnt == HALF_END) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_in ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == BIT_END) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_in, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state_n = RX_STOP;
               else                rx_bit_n   = rx_bit + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == BIT_END) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_IDLE;
               rx_valid_n = rx_in;
               rx_err_n   = !rx_in;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      case (tx_state)
         TX_IDLE: begin
            tx_cnt_n = '0;
            tx_bit_n = '0;
            if (tx_start) begin
               tx_shift_n = {1'b1, tx_data, 1'b0};
               tx_state_n = TX_SEND;
            end
         end
         TX_SEND: begin
            tx_cnt_n = tx_cnt + 1'b1;
            if (tx_cnt == BIT_END) begin
               tx_cnt_n   = '0;
               tx_shift_n = {1'b1, tx_shift[9:1]};
               if (tx_bit == 4'd9) tx_state_n = TX_IDLE;
               else                tx_bit_n   = tx_bit + 4'd1;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_bus_master.sv
// Host debug initiator: parses 'W'/'R' byte commands from UART and issues single 32-bit bus accesses.
module uart_bus_master
   import uart_bus_pkg::*;
#(
   parameter int CLK_DIV       = CLK_DIV_DEFAULT,
   parameter int FRAME_TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        RXD,
   output logic        TXD,
   output logic        req,
   output logic [31:0] addr,
   output logic        we,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic        gnt,
   input  logic        rvalid,
   input  logic [31:0] rdata,
   input  logic        err,
   output logic        busy,
   output dbg_t        dbg
);

   localparam int TW = $clog2(FRAME_TIMEOUT);
   localparam logic [TW-1:0] TMO_END = TW'(FRAME_TIMEOUT - 1);

   logic [1:0]    rst_sync;
   logic          rst_n;
   logic          rx_valid, rx_frame_err, tx_start, tx_busy;
   logic [7:0]    rx_data, tx_data;
   rx_state_t     rx_state;
   tx_state_t     tx_state;

   state_t        state, state_n;
   logic          we_n, req_n;
   logic [1:0]    byte_cnt, byte_cnt_n;
   logic [31:0]   addr_n, wdata_n;
   logic [31:0]   resp_buf, resp_buf_n;
   logic [2:0]    resp_left, resp_left_n;
   logic [TW-1:0] tmo, tmo_n;

   // Assertion is asynchronous; release is synchronised to clk.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   uart_phy #(.CLK_DIV(CLK_DIV)) u_phy (
      .clk          (clk),
      .rst_n        (rst_n),
      .rxd          (RXD),
      .txd          (TXD),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_frame_err (rx_frame_err),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .rx_state     (rx_state),
      .tx_state     (tx_state)
   );

   assign be      = 4'hF;
   assign busy    = (state != IDLE);
   assign tx_data = resp_buf[31:24];
   assign dbg     = '{cmd: state, rx: rx_state, tx: tx_state};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         we        <= 1'b0;
         req       <= 1'b0;
         byte_cnt  <= '0;
         addr      <= '0;
         wdata     <= '0;
         resp_buf  <= '0;
         resp_left <= '0;
         tmo       <= '0;
      end else begin
         state     <= state_n;
         we        <= we_n;
         req       <= req_n;
         byte_cnt  <= byte_cnt_n;
         addr      <= addr_n;
         wdata     <= wdata_n;
         resp_buf  <= resp_buf_n;
         resp_left <= resp_left_n;
         tmo       <= tmo_n;
      end
   end

   // Bus handshake: req holds addr/we/wdata/be stable until gnt is sampled high with req;
   // the response is rvalid (with rdata/err), taken only from the cycle after gnt.
   always_comb begin
      state_n     = state;
      we_n        = we;
      req_n       = req;
      byte_cnt_n  = byte_cnt;
      addr_n      = addr;
      wdata_n     = wdata;
      resp_buf_n  = resp_buf;
      resp_left_n = resp_left;
      tmo_n       = '0;
      tx_start    = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                  we_n       = (rx_data == CMD_WRITE);
                  byte_cnt_n = '0;
                  state_n    = ADDR;
               end else begin
                  resp_buf_n  = {RSP_UNK, 24'h0};
                  resp_left_n = 3'd1;
                  state_n     = RESP;
               end
            end
         end
         ADDR, DATA: begin
            tmo_n = rx_valid ? '0 : tmo + 1'b1;
            if (rx_frame_err) begin
               state_n = IDLE;
            end else if (rx_valid) begin
               byte_cnt_n = byte_cnt + 2'd1;
               if (state == ADDR) addr_n  = {addr[23:0], rx_data};
               else               wdata_n = {wdata[23:0], rx_data};
               if (byte_cnt == 2'd3) state_n = (state == ADDR && we) ? DATA : BUS;
            end else if (tmo == TMO_END) begin
               state_n = IDLE;
            end
         end
         BUS: begin
            if (!req) begin
               req_n = 1'b1;
            end else if (gnt) begin
               req_n   = 1'b0;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (rvalid) begin
               state_n = RESP;
               if (err) begin
                  resp_buf_n  = {RSP_ERR, 24'h0};
                  resp_left_n = 3'd1;
               end else if (we) begin
                  resp_buf_n  = {RSP_OK, 24'h0};
                  resp_left_n = 3'd1;
               end else begin
                  resp_buf_n  = rdata;
                  resp_left_n = 3'd4;
               end
            end
         end
         RESP: begin
            // Leave only once the last byte's stop bit has gone out.
            if (!tx_busy) begin
               if (resp_left != 3'd0) begin
                  tx_start    = 1'b1;
                  resp_buf_n  = {resp_buf[23:0], 8'h00};
                  resp_left_n = resp_left - 3'd1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: UART host driver, bus slave model and TX byte scoreboard.
module tb_uart_bus_master;
   import uart_bus_pkg::*;

   localparam int CLK_DIV       = 16;
   localparam int FRAME_TIMEOUT = 2000;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } bus_exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        RXD = 1'b1;
   logic        TXD, req, we, busy;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   dbg_t        dbg;

   logic [7:0] exp_q[$];
   bus_exp_t   bus_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         gnt_delay = 0;
   logic       rv_err = 1'b0;
   logic [31:0] rv_data = 32'h0;
   bit         rst_seen = 1'b0;

   uart_bus_master #(.CLK_DIV(CLK_DIV), .FRAME_TIMEOUT(FRAME_TIMEOUT)) dut (
      .clk(clk), .resetn(resetn), .RXD(RXD), .TXD(TXD), .req(req), .addr(addr),
      .we(we), .be(be), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .err(err), .busy(busy), .dbg(dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial forever begin
      @(negedge resetn);
      rst_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
      RXD = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      RXD = !bad_stop;
      repeat (CLK_DIV) @(negedge clk);
      RXD = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("busy_clear", busy, 1'b0);
      repeat (3 * CLK_DIV) @(negedge clk);
   endtask

   // bus slave: grants after gnt_delay stall cycles, answers the following cycle
   initial begin : slave
      int       stall;
      bit       pend;
      bus_exp_t e;
      stall = 0; pend = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; err = 1'b0;
      forever begin
         @(negedge clk);
         gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
         if (!resetn) begin
            stall = 0; pend = 1'b0;
         end else begin
            if (pend) begin
               rvalid = 1'b1; rdata = rv_data; err = rv_err; pend = 1'b0;
            end
            if (req) begin
               if (bus_q.size() == 0) begin
                  check("unexpected_req", req, 1'b0);
                  gnt = 1'b1; pend = 1'b1;
               end else if (stall < gnt_delay) begin
                  stall++;
                  check("stall_addr", addr, bus_q[0].addr);
                  check("stall_we", we, bus_q[0].we);
               end else begin
                  e = bus_q.pop_front();
                  check("bus_addr", addr, e.addr);
                  check("bus_we", we, e.we);
                  check("bus_be", be, 4'hF);
                  if (e.we) check("bus_wdata", wdata, e.wdata);
                  gnt = 1'b1; pend = 1'b1; stall = 0;
               end
            end
         end
      end
   end

   // TX monitor: decodes each frame and pops the scoreboard
   initial begin : tx_mon
      logic [7:0] b;
      logic       stop_bit;
      b = 8'h0;
      forever begin
         @(negedge clk);
         if (resetn && TXD === 1'b0) begin
            rst_seen = 1'b0;
            repeat (CLK_DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CLK_DIV) @(negedge clk);
               b[i] = TXD;
            end
            repeat (CLK_DIV) @(negedge clk);
            stop_bit = TXD;
            if (!rst_seen) begin
               check("tx_stop", stop_bit, 1'b1);
               check("tx_byte_expected", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) check("tx_byte", b, exp_q.pop_front());
            end
         end
      end
   end

   initial begin : stimulus
      // reset values, during and after reset
      repeat (5) @(negedge clk);
      check("rst_txd", TXD, 1'b1);
      check("rst_req", req, 1'b0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_we", we, 1'b0);
      check("rst_be", be, 4'hF);
      check("rst_addr", addr, 32'h0);
      check("rst_wdata", wdata, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", dbg.cmd, IDLE);

      // write, zero-wait slave
      bus_q.push_back('{32'h1000_0004, 1'b1, 32'hDEAD_BEEF});
      exp_q.push_back(RSP_OK);
      send_byte(CMD_WRITE);
      send_word(32'h1000_0004);
      send_word(32'hDEAD_BEEF);
      wait_idle(3000);

      // read with 5 stall cycles
      gnt_delay = 5;
      rv_data = 32'h1234_5678;
      bus_q.push_back('{32'h9A10_0010, 1'b0, 32'h0});
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      exp_q.push_back(8'h56); exp_q.push_back(8'h78);
      send_byte(CMD_READ);
      send_word(32'h9A10_0010);
      wait_idle(3000);
      gnt_delay = 0;

      // read answered with err
      rv_err = 1'b1;
      bus_q.push_back('{32'h0000_0030, 1'b0, 32'h0});
      exp_q.push_back(RSP_ERR);
      send_byte(CMD_READ);
      send_word(32'h0000_0030);
      wait_idle(3000);
      check("err_state", dbg.cmd, IDLE);
      rv_err = 1'b0;

      // unknown opcode
      exp_q.push_back(RSP_UNK);
      send_byte(8'h41);
      wait_idle(3000);

      // partial frame dropped by timeout, then a clean read
      send_byte(CMD_WRITE);
      send_byte(8'h00);
      check("partial_busy", busy, 1'b1);
      repeat (FRAME_TIMEOUT + 100) @(negedge clk);
      check("timeout_busy", busy, 1'b0);
      rv_data = 32'hA5A5_5A5A;
      bus_q.push_back('{32'h0000_0020, 1'b0, 32'h0});
      exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
      send_byte(CMD_READ);
      send_word(32'h0000_0020);
      wait_idle(3000);

      // framing error on the 3rd address byte: nothing issued, nothing sent
      send_byte(CMD_READ);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33, 1'b1);
      repeat (CLK_DIV) @(negedge clk);
      check("frame_err_busy", busy, 1'b0);
      repeat (200) @(negedge clk);
      bus_q.push_back('{32'h0000_0008, 1'b1, 32'h0102_0304});
      exp_q.push_back(RSP_OK);
      send_byte(CMD_WRITE);
      send_word(32'h0000_0008);
      send_word(32'h0102_0304);
      wait_idle(3000);

      // reset while req is held by a stalling slave
      gnt_delay = 1000;
      bus_q.push_back('{32'h0000_0040, 1'b0, 32'h0});
      send_byte(CMD_READ);
      send_word(32'h0000_0040);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req) break;
      end
      check("req_before_reset", req, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("reset_req_drop", req, 1'b0);
      check("reset_txd_idle", TXD, 1'b1);
      check("reset_busy", busy, 1'b0);
      bus_q.delete();
      gnt_delay = 0;
      repeat (5) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // reset in the middle of a response frame
      rv_data = 32'hCAFE_F00D;
      bus_q.push_back('{32'h0000_0044, 1'b0, 32'h0});
      send_byte(CMD_READ);
      send_word(32'h0000_0044);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (TXD === 1'b0) break;
      end
      check("resp_started", TXD, 1'b0);
      repeat (40) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("reset_tx_trunc", TXD, 1'b1);
      check("reset_tx_busy", busy, 1'b0);
      repeat (5) @(negedge clk);
      resetn = 1'b1;
      repeat (200) @(negedge clk);

      // normal write after reset
      bus_q.push_back('{32'h0000_0100, 1'b1, 32'h55AA_55AA});
      exp_q.push_back(RSP_OK);
      send_byte(CMD_WRITE);
      send_word(32'h0000_0100);
      send_word(32'h55AA_55AA);
      wait_idle(3000);

      check("tx_queue_empty", exp_q.size(), 0);
      check("bus_queue_empty", bus_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
